// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART peripheral controller: FSM states,
// control-register bit positions and the fixed control words.
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        POLL       = 3'd1,
        RX_SEL     = 3'd2,
        RX_CAPTURE = 3'd3,
        RX_CLEAR   = 3'd4,
        TX_LOAD    = 3'd5,
        TX_START   = 3'd6,
        TX_WAIT    = 3'd7
    } state_t;

    localparam int TX_BUSY = 0;
    localparam int RX_PEND = 1;

    localparam logic [31:0] CTRL_START = 32'h0000_0001;
    localparam logic [31:0] CTRL_CLEAR = 32'h0000_0000;

endpackage

// File: rtl/uart_byte_fifo.sv
// First-word fall-through FIFO with occupancy counter; a push into a full
// FIFO is accepted when a pop happens in the same cycle.
module uart_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_reg];
    assign count   = count_reg;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/uart_ctrl_fifo.sv
// Polls a memory-mapped UART, drains received bytes into an RX FIFO and
// feeds bytes from a TX FIFO; RX is always serviced before TX.
module uart_ctrl_fifo
    import uart_ctrl_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int TX_DEPTH   = 8,
    parameter int RX_DEPTH   = 8,
    parameter int TX_TIMEOUT = 100000
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        enable_i,
    input  logic [31:0]                 salida_perif_UART_i,
    output logic                        wr_o,
    output logic                        reg_sel_o,
    output logic [31:0]                 entrada_perif_UART_o,
    input  logic [DATA_W-1:0]           tx_data_i,
    input  logic                        tx_valid_i,
    output logic                        tx_ready_o,
    output logic [DATA_W-1:0]           rx_data_o,
    output logic                        rx_valid_o,
    input  logic                        rx_ready_i,
    output logic [$clog2(TX_DEPTH):0]   tx_count_o,
    output logic [$clog2(RX_DEPTH):0]   rx_count_o,
    output logic                        rx_overflow_o,
    output logic                        tx_timeout_o,
    input  logic                        clr_err_i
);
    localparam int TO_W = $clog2(TX_TIMEOUT + 1);

    state_t            state_reg, state_next;
    logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
    logic              rx_overflow_reg, tx_timeout_reg;
    logic              set_overflow, set_timeout;
    logic              tx_pop, rx_push;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [DATA_W-1:0] tx_head;

    uart_byte_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk_i),
        .srst      (reset_i),
        .push      (tx_valid_i && tx_ready_o),
        .push_data (tx_data_i),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (tx_count_o),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    uart_byte_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk_i),
        .srst      (reset_i),
        .push      (rx_push),
        .push_data (salida_perif_UART_i[DATA_W-1:0]),
        .pop       (rx_ready_i),
        .head      (rx_data_o),
        .count     (rx_count_o),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    assign tx_ready_o    = !tx_full;
    assign rx_valid_o    = !rx_empty;
    assign rx_overflow_o = rx_overflow_reg;
    assign tx_timeout_o  = tx_timeout_reg;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg       <= IDLE;
            to_cnt_reg      <= '0;
            rx_overflow_reg <= 1'b0;
            tx_timeout_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            to_cnt_reg <= to_cnt_next;
            // A same-cycle set wins over the clear request.
            if (set_overflow)
                rx_overflow_reg <= 1'b1;
            else if (clr_err_i)
                rx_overflow_reg <= 1'b0;
            if (set_timeout)
                tx_timeout_reg <= 1'b1;
            else if (clr_err_i)
                tx_timeout_reg <= 1'b0;
        end
    end

    always_comb begin
        state_next           = state_reg;
        to_cnt_next          = to_cnt_reg;
        wr_o                 = 1'b0;
        reg_sel_o            = 1'b0;
        entrada_perif_UART_o = '0;
        tx_pop               = 1'b0;
        rx_push              = 1'b0;
        set_overflow         = 1'b0;
        set_timeout          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable_i)
                    state_next = POLL;
            end
            POLL: begin
                if (salida_perif_UART_i[RX_PEND])
                    state_next = RX_SEL;
                else if (!tx_empty)
                    state_next = TX_LOAD;
                else if (!enable_i)
                    state_next = IDLE;
            end
            RX_SEL: begin
                reg_sel_o  = 1'b1;
                state_next = RX_CAPTURE;
            end
            RX_CAPTURE: begin
                // A full FIFO still accepts the byte if the user pops this cycle.
                reg_sel_o    = 1'b1;
                rx_push      = 1'b1;
                set_overflow = rx_full && !rx_ready_i;
                state_next   = RX_CLEAR;
            end
            RX_CLEAR: begin
                wr_o                 = 1'b1;
                entrada_perif_UART_o = CTRL_CLEAR;
                state_next           = POLL;
            end
            TX_LOAD: begin
                reg_sel_o                         = 1'b1;
                wr_o                              = 1'b1;
                entrada_perif_UART_o[DATA_W-1:0]  = tx_head;
                tx_pop                            = 1'b1;
                state_next                        = TX_START;
            end
            TX_START: begin
                wr_o                 = 1'b1;
                entrada_perif_UART_o = CTRL_START;
                to_cnt_next          = '0;
                state_next           = TX_WAIT;
            end
            TX_WAIT: begin
                // Busy is ignored on the first wait cycle; a timeout reuses
                // RX_CLEAR to write the zero control word.
                to_cnt_next = to_cnt_reg + 1'b1;
                if ((to_cnt_reg != '0) && !salida_perif_UART_i[TX_BUSY]) begin
                    state_next = POLL;
                end else if (to_cnt_next == TO_W'(TX_TIMEOUT)) begin
                    set_timeout = 1'b1;
                    state_next  = RX_CLEAR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_ctrl_fifo.sv
// Directed bench for uart_ctrl_fifo with a behavioural UART peripheral and
// scoreboards for peripheral writes and RX data.
module tb_uart_ctrl_fifo;
    import uart_ctrl_pkg::*;

    localparam int DATA_W     = 8;
    localparam int TX_DEPTH   = 8;
    localparam int RX_DEPTH   = 8;
    localparam int TX_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset_i, enable_i, clr_err_i, tx_valid_i, rx_ready_i;
    logic [31:0] salida_perif_UART_i;
    logic        wr_o, reg_sel_o;
    logic [31:0] entrada_perif_UART_o;
    logic [7:0]  tx_data_i;
    logic        tx_ready_o;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic [3:0]  tx_count_o, rx_count_o;
    logic        rx_overflow_o, tx_timeout_o;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_wr[$];
    logic [7:0]  exp_rx[$];
    logic [7:0]  rx_q[$];
    logic        tx_busy = 1'b0;
    int          busy_cnt = 0;
    int          busy_len = 4;
    logic        rx_pend = 1'b0;
    logic [7:0]  rx_head = 8'h00;
    int          sel_run = 0;
    int          last_sel_run = 0;
    int          wait_cycles = 0;

    uart_ctrl_fifo #(
        .DATA_W(DATA_W), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .TX_TIMEOUT(TX_TIMEOUT)
    ) dut (
        .clk_i                (clk),
        .reset_i              (reset_i),
        .enable_i             (enable_i),
        .salida_perif_UART_i  (salida_perif_UART_i),
        .wr_o                 (wr_o),
        .reg_sel_o            (reg_sel_o),
        .entrada_perif_UART_o (entrada_perif_UART_o),
        .tx_data_i            (tx_data_i),
        .tx_valid_i           (tx_valid_i),
        .tx_ready_o           (tx_ready_o),
        .rx_data_o            (rx_data_o),
        .rx_valid_o           (rx_valid_o),
        .rx_ready_i           (rx_ready_i),
        .tx_count_o           (tx_count_o),
        .rx_count_o           (rx_count_o),
        .rx_overflow_o        (rx_overflow_o),
        .tx_timeout_o         (tx_timeout_o),
        .clr_err_i            (clr_err_i)
    );

    always #5 clk = ~clk;

    assign salida_perif_UART_i = reg_sel_o ? {24'h0, rx_head} : {30'h0, rx_pend, tx_busy};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Peripheral model and write monitor; all updates on the falling edge.
    always @(negedge clk) begin
        logic [32:0] w;
        if (reg_sel_o === 1'b1) begin
            sel_run++;
        end else begin
            if (sel_run > 0) last_sel_run = sel_run;
            sel_run = 0;
        end
        if (dut.state_reg === TX_WAIT) wait_cycles++;
        if (tx_busy) begin
            if (busy_cnt <= 1) tx_busy = 1'b0;
            else busy_cnt--;
        end
        if (wr_o === 1'b1) begin
            w = {reg_sel_o, entrada_perif_UART_o};
            $display("[%0t] write reg_sel=%0d data=%08h", $time, reg_sel_o, entrada_perif_UART_o);
            checks++;
            assert (exp_wr.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write: got %0h expected none", w);
            end
            if (exp_wr.size() != 0) check("write", 64'(w), 64'(exp_wr.pop_front()));
            if (reg_sel_o === 1'b0) begin
                if (entrada_perif_UART_o == 32'h1) begin
                    tx_busy  = 1'b1;
                    busy_cnt = busy_len;
                end else begin
                    tx_busy = 1'b0;
                    if (rx_q.size() != 0) void'(rx_q.pop_front());
                end
            end
        end
        rx_pend = (rx_q.size() != 0);
        rx_head = rx_pend ? rx_q[0] : 8'h00;
    end

    task automatic push_tx(input logic [7:0] b);
        tx_data_i  = b;
        tx_valid_i = 1'b1;
        @(negedge clk);
        tx_valid_i = 1'b0;
    endtask

    task automatic expect_tx(input logic [7:0] b);
        exp_wr.push_back({1'b1, 24'h0, b});
        exp_wr.push_back({1'b0, 32'h1});
    endtask

    task automatic add_rx(input logic [7:0] b, input bit keep);
        rx_q.push_back(b);
        exp_wr.push_back({1'b0, 32'h0});
        if (keep) exp_rx.push_back(b);
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int n = 0;
        while (n < budget && !(exp_wr.size() == 0 && rx_q.size() == 0 && !tx_busy &&
                               dut.state_reg === POLL && tx_count_o == 4'd0)) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n < budget), 64'd1);
    endtask

    task automatic pop_rx(input string tag);
        int n = 0;
        logic [7:0] e;
        while (n < 50 && rx_valid_o !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 64'(rx_valid_o), 64'd1);
        e = (exp_rx.size() != 0) ? exp_rx.pop_front() : 8'hxx;
        check({tag, "_data"}, 64'(rx_data_o), 64'(e));
        $display("[%0t] rx pop data=%02h", $time, rx_data_o);
        rx_ready_i = 1'b1;
        @(negedge clk);
        rx_ready_i = 1'b0;
    endtask

    initial begin
        int n;
        reset_i = 1'b1; enable_i = 1'b0; clr_err_i = 1'b0;
        tx_valid_i = 1'b0; rx_ready_i = 1'b0; tx_data_i = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_wr", 64'(wr_o), 64'd0);
        check("rst_sel", 64'(reg_sel_o), 64'd0);
        check("rst_bus", 64'(entrada_perif_UART_o), 64'd0);
        check("rst_state", 64'(dut.state_reg), 64'(IDLE));
        check("rst_txcnt", 64'(tx_count_o), 64'd0);
        check("rst_rxcnt", 64'(rx_count_o), 64'd0);
        check("rst_txrdy", 64'(tx_ready_o), 64'd1);
        check("rst_rxval", 64'(rx_valid_o), 64'd0);
        check("rst_flags", 64'({rx_overflow_o, tx_timeout_o}), 64'd0);
        reset_i = 1'b0; enable_i = 1'b1;
        repeat (2) @(negedge clk);
        check("enter_poll", 64'(dut.state_reg), 64'(POLL));

        // Single TX byte with busy held for 10 cycles.
        busy_len = 10;
        expect_tx(8'hA5);
        push_tx(8'hA5);
        check("tx_count_one", 64'(tx_count_o), 64'd1);
        wait_quiet("tx_done", 100);
        check("tx_count_zero", 64'(tx_count_o), 64'd0);
        check("no_timeout", 64'(tx_timeout_o), 64'd0);

        // Single RX byte.
        add_rx(8'h3C, 1'b1);
        wait_quiet("rx_done", 100);
        check("rx_sel_cycles", 64'(last_sel_run), 64'd2);
        check("rx_count_one", 64'(rx_count_o), 64'd1);
        pop_rx("rx_3c");
        check("rx_count_after", 64'(rx_count_o), 64'd0);

        // Overflow: one more byte than the RX FIFO holds.
        for (int i = 0; i <= RX_DEPTH; i++) add_rx(8'(8'h10 + i), i < RX_DEPTH);
        wait_quiet("ovf_done", 600);
        check("ovf_count", 64'(rx_count_o), 64'(RX_DEPTH));
        check("ovf_flag", 64'(rx_overflow_o), 64'd1);
        clr_err_i = 1'b1;
        @(negedge clk);
        clr_err_i = 1'b0;
        check("ovf_clear", 64'(rx_overflow_o), 64'd0);
        for (int i = 0; i < RX_DEPTH; i++) pop_rx("ovf_pop");
        check("ovf_drained", 64'(rx_count_o), 64'd0);

        // RX and TX pending in the same poll: RX goes first.
        enable_i = 1'b0;
        repeat (3) @(negedge clk);
        check("back_idle", 64'(dut.state_reg), 64'(IDLE));
        busy_len = 3;
        add_rx(8'h77, 1'b1);
        expect_tx(8'h5A);
        push_tx(8'h5A);
        repeat (2) @(negedge clk);
        enable_i = 1'b1;
        wait_quiet("prio_done", 200);
        pop_rx("prio_rx");
        check("prio_txcnt", 64'(tx_count_o), 64'd0);

        // TX timeout with busy stuck high.
        busy_len = 1000;
        wait_cycles = 0;
        expect_tx(8'hC3);
        exp_wr.push_back({1'b0, 32'h0});
        push_tx(8'hC3);
        wait_quiet("to_done", 200);
        check("to_wait_cycles", 64'(wait_cycles), 64'(TX_TIMEOUT));
        check("to_flag", 64'(tx_timeout_o), 64'd1);
        clr_err_i = 1'b1;
        @(negedge clk);
        clr_err_i = 1'b0;
        check("to_clear", 64'(tx_timeout_o), 64'd0);

        // Reset while in TX_LOAD abandons the transaction.
        busy_len = 4;
        exp_wr.push_back({1'b1, 24'h0, 8'h99});
        push_tx(8'h99);
        push_tx(8'h66);
        n = 0;
        while (n < 20 && dut.state_reg !== TX_LOAD) begin
            @(negedge clk);
            n++;
        end
        check("reach_txload", 64'(dut.state_reg), 64'(TX_LOAD));
        reset_i = 1'b1;
        @(negedge clk);
        check("rst_mid_wr", 64'(wr_o), 64'd0);
        check("rst_mid_state", 64'(dut.state_reg), 64'(IDLE));
        check("rst_mid_txcnt", 64'(tx_count_o), 64'd0);
        check("rst_mid_rxcnt", 64'(rx_count_o), 64'd0);
        reset_i = 1'b0;
        repeat (20) @(negedge clk);
        check("no_pending_wr", 64'(exp_wr.size()), 64'd0);
        check("no_pending_rx", 64'(exp_rx.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
